// File: rtl/ddr3_dll_upd_pkg.sv
// Shared types and default timing constants for the DQSDLLB update sequencer.
package ddr3_dll_upd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOCKWAIT = 3'd1,
      ST_WAITACK0 = 3'd2,
      ST_REQ      = 3'd3,
      ST_UPDATE   = 3'd4,
      ST_SETTLE   = 3'd5,
      ST_READY    = 3'd6
   } state_e;

   localparam int unsigned LOCK_WAIT_DEF  = 256;
   localparam int unsigned UPD_PERIOD_DEF = 8192;
   localparam int unsigned UPD_WIDTH_DEF  = 4;
   localparam int unsigned SETTLE_DEF     = 16;
   localparam int unsigned CNT_W_DEF      = 14;

   // The controller window is considered in use from request until settle ends.
   function automatic logic is_busy(input state_e s);
      return (s == ST_REQ) || (s == ST_UPDATE) || (s == ST_SETTLE);
   endfunction

endpackage

// File: rtl/ddr3_dll_upd_if.sv
// Lock input, controller handshake and status signals of the DLL update sequencer.
interface ddr3_dll_upd_if;

   logic all_lock;
   logic upd_force;
   logic upd_ack;
   logic upd_req;
   logic uddcntln;
   logic dll_ready;
   logic upd_busy;
   logic lock_lost;

   modport master (
      input  all_lock, upd_force, upd_ack,
      output upd_req, uddcntln, dll_ready, upd_busy, lock_lost
   );

   modport slave (
      output all_lock, upd_force, upd_ack,
      input  upd_req, uddcntln, dll_ready, upd_busy, lock_lost
   );

endinterface

// File: rtl/ddr3_sync2.sv
// Two-flop synchronizer for asynchronous status inputs, resets to 0.
module ddr3_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ddr3_dll_upd.sv
// Sequences initial and periodic DQSDLLB code updates inside controller-granted
// idle windows, and reports DLL readiness and lock loss.
module ddr3_dll_upd
   import ddr3_dll_upd_pkg::*;
#(
   parameter int unsigned LOCK_WAIT  = LOCK_WAIT_DEF,
   parameter int unsigned UPD_PERIOD = UPD_PERIOD_DEF,
   parameter int unsigned UPD_WIDTH  = UPD_WIDTH_DEF,
   parameter int unsigned SETTLE     = SETTLE_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic                  sclk,
   input  logic                  reset_n,
   ddr3_dll_upd_if.master        bus
);

   localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCK_WAIT - 1);
   localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(UPD_PERIOD - 1);
   localparam logic [CNT_W-1:0] WIDTH_LD  = CNT_W'(UPD_WIDTH - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pending_q, pending_d;
   logic             req_q, req_d;
   logic             udd_q, udd_d;
   logic             rdy_q, rdy_d;
   logic             busy_q, busy_d;
   logic             lost_q, lost_d;
   logic             lock_s;
   logic             cnt_zero;

   ddr3_sync2 u_lock_sync (
      .clk   (sclk),
      .rst_n (reset_n),
      .d     (bus.all_lock),
      .q     (lock_s)
   );

   assign cnt_zero = (cnt_q == '0);

   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         req_q     <= 1'b0;
         udd_q     <= 1'b1;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b0;
         lost_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         req_q     <= req_d;
         udd_q     <= udd_d;
         rdy_q     <= rdy_d;
         busy_q    <= busy_d;
         lost_q    <= lost_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      req_d     = req_q;
      udd_d     = udd_q;
      rdy_d     = rdy_q;
      lost_d    = 1'b0;

      // Forces outside READY are remembered; the next granted update consumes them.
      if (bus.upd_force && (state_q != ST_READY)) pending_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (lock_s) begin
               cnt_d   = LOCK_LD;
               state_d = ST_LOCKWAIT;
            end
         end
         ST_LOCKWAIT: begin
            if (cnt_zero) state_d = ST_WAITACK0;
            else          cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_WAITACK0: begin
            if (!bus.upd_ack) begin
               req_d   = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.upd_ack) begin
               udd_d     = 1'b0;
               cnt_d     = WIDTH_LD;
               pending_d = 1'b0;
               state_d   = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            if (cnt_zero) begin
               udd_d   = 1'b1;
               cnt_d   = SETTLE_LD;
               state_d = ST_SETTLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_SETTLE: begin
            if (cnt_zero) begin
               req_d   = 1'b0;
               rdy_d   = 1'b1;
               cnt_d   = PERIOD_LD;
               state_d = ST_READY;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_READY: begin
            if (cnt_zero || bus.upd_force || pending_q) state_d = ST_WAITACK0;
            else                                        cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      // Lock loss overrides every other transition, including a same-cycle grant.
      if ((state_q != ST_IDLE) && !lock_s) begin
         state_d   = ST_IDLE;
         req_d     = 1'b0;
         udd_d     = 1'b1;
         rdy_d     = 1'b0;
         pending_d = 1'b0;
         lost_d    = 1'b1;
      end

      busy_d = is_busy(state_d);
   end

   assign bus.upd_req   = req_q;
   assign bus.uddcntln  = udd_q;
   assign bus.dll_ready = rdy_q;
   assign bus.upd_busy  = busy_q;
   assign bus.lock_lost = lost_q;

endmodule

// File: tb/tb_ddr3_dll_upd.sv
// Directed bench for ddr3_dll_upd with LOCK_WAIT=8, UPD_PERIOD=32, UPD_WIDTH=3, SETTLE=4.
// Edge numbering: the first edge that samples a changed all_lock is edge 0.
module tb_ddr3_dll_upd;

   logic sclk;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   ddr3_dll_upd_if bus ();

   ddr3_dll_upd #(
      .LOCK_WAIT  (8),
      .UPD_PERIOD (32),
      .UPD_WIDTH  (3),
      .SETTLE     (4),
      .CNT_W      (14)
   ) dut (
      .sclk    (sclk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   task automatic step(input int n);
      repeat (n) @(posedge sclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic req, input logic udd,
                          input logic rdy, input logic busy, input logic lost);
      chk({tag, ".upd_req"},   bus.upd_req,   req);
      chk({tag, ".uddcntln"},  bus.uddcntln,  udd);
      chk({tag, ".dll_ready"}, bus.dll_ready, rdy);
      chk({tag, ".upd_busy"},  bus.upd_busy,  busy);
      chk({tag, ".lock_lost"}, bus.lock_lost, lost);
   endtask

   initial begin
      reset_n       = 1'b0;
      bus.all_lock  = 1'b0;
      bus.upd_force = 1'b0;
      bus.upd_ack   = 1'b0;
      step(3);
      chk_all("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      step(2);
      chk_all("idle_no_lock", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Power-up: request must appear after edge 11, not before.
      bus.all_lock = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         step(1);
         chk_all("pwr_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      step(1);
      chk_all("pwr_req", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

      // Initial update: grant two cycles after request.
      step(2);
      chk_all("req_hold", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      bus.upd_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk_all("init_udd_low", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      step(1);
      chk_all("init_udd_rel", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk_all("init_settle", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      step(1);
      chk_all("init_done", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Periodic: ack drops one cycle after req falls; next req 33 cycles after fall.
      step(1);
      bus.upd_ack = 1'b0;
      for (int i = 0; i < 31; i++) begin
         step(1);
         chk("per_wait.upd_req", bus.upd_req, 1'b0);
      end
      step(1);
      chk_all("per_req", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      bus.upd_ack = 1'b1;
      step(1);
      chk("per_grant.uddcntln", bus.uddcntln, 1'b0);
      step(3);
      chk("per_rel.uddcntln", bus.uddcntln, 1'b1);
      step(4);
      chk_all("per_done", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Ack left high past the period: no new request until ack drops.
      step(33);
      chk_all("ack_stuck", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(2);
      chk("ack_stuck2.upd_req", bus.upd_req, 1'b0);
      bus.upd_ack = 1'b0;
      step(1);
      chk("ack_drop.upd_req", bus.upd_req, 1'b1);
      bus.upd_ack = 1'b1;
      step(1);
      chk("ack_grant.uddcntln", bus.uddcntln, 1'b0);
      step(3);
      step(4);
      chk("ack_done.upd_req", bus.upd_req, 1'b0);
      bus.upd_ack = 1'b0;

      // Force in READY with counter at 20.
      step(11);
      bus.upd_force = 1'b1;
      step(1);
      bus.upd_force = 1'b0;
      chk("force20_a.upd_req", bus.upd_req, 1'b0);
      step(1);
      chk("force20_b.upd_req", bus.upd_req, 1'b1);

      // Force during UPDATE: exactly one extra update right after READY entry.
      bus.upd_ack = 1'b1;
      step(1);
      chk("fupd_grant.uddcntln", bus.uddcntln, 1'b0);
      bus.upd_force = 1'b1;
      step(1);
      bus.upd_force = 1'b0;
      step(6);
      chk_all("fupd_done", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      bus.upd_ack = 1'b0;
      step(1);
      chk("fupd_ready.upd_req", bus.upd_req, 1'b0);
      step(1);
      chk("fupd_extra.upd_req", bus.upd_req, 1'b1);
      bus.upd_ack = 1'b1;
      step(8);
      chk("fupd_extra_done.upd_req", bus.upd_req, 1'b0);
      bus.upd_ack = 1'b0;
      step(2);
      chk("fupd_no_third.upd_req", bus.upd_req, 1'b0);

      // Force coincident with the READY counter reaching 0: one update only.
      step(29);
      bus.upd_force = 1'b1;
      step(1);
      bus.upd_force = 1'b0;
      chk("fzero_a.upd_req", bus.upd_req, 1'b0);
      step(1);
      chk("fzero_b.upd_req", bus.upd_req, 1'b1);
      bus.upd_ack = 1'b1;
      step(8);
      chk("fzero_done.upd_req", bus.upd_req, 1'b0);
      bus.upd_ack = 1'b0;
      step(3);
      chk("fzero_single.upd_req", bus.upd_req, 1'b0);

      // Lock loss while uddcntln is held low.
      bus.upd_force = 1'b1;
      step(1);
      bus.upd_force = 1'b0;
      step(1);
      chk("ll_req.upd_req", bus.upd_req, 1'b1);
      step(2);
      bus.upd_ack  = 1'b1;
      bus.all_lock = 1'b0;
      step(1);
      chk_all("ll_e0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1);
      chk_all("ll_e1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1);
      chk_all("ll_e2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1);
      chk_all("ll_e3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Relock repeats the full lock-wait sequence.
      bus.upd_ack  = 1'b0;
      bus.all_lock = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         step(1);
         chk("relock_wait.upd_req", bus.upd_req, 1'b0);
      end
      step(1);
      chk_all("relock_req", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset during REQ with ack high, between clock edges.
      #3;
      bus.upd_ack = 1'b1;
      reset_n     = 1'b0;
      #1;
      chk_all("async_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(2);
      chk_all("async_rst_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      step(2);
      chk_all("async_rst_rel", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
